// File: rtl/xillybus_lite_mailbox_pkg.sv
// Shared constants for the Xillybus Lite mailbox: register map, bit positions, default ID.
package xillybus_lite_mailbox_pkg;

    localparam int unsigned DATA_W = 32;
    localparam logic [DATA_W-1:0] DEFAULT_ID_VALUE = 32'h4D42_0001;

    // Word offsets (user_addr[ADDR_W-1:2])
    localparam int unsigned REG_ID     = 0;
    localparam int unsigned REG_CTRL   = 1;
    localparam int unsigned REG_STATUS = 2;
    localparam int unsigned REG_H2F    = 3;
    localparam int unsigned REG_F2H    = 4;

    localparam int unsigned CTRL_IRQ_EN    = 0;
    localparam int unsigned CTRL_H2F_FLUSH = 1;
    localparam int unsigned CTRL_F2H_FLUSH = 2;

    localparam int unsigned ST_H2F_FULL    = 0;
    localparam int unsigned ST_H2F_EMPTY   = 1;
    localparam int unsigned ST_F2H_FULL    = 2;
    localparam int unsigned ST_F2H_EMPTY   = 3;
    localparam int unsigned ST_H2F_OVF     = 4;
    localparam int unsigned ST_F2H_UNF     = 5;
    localparam int unsigned ST_F2H_CNT_LSB = 8;
    localparam int unsigned ST_H2F_CNT_LSB = 16;
    localparam int unsigned ST_CNT_W       = 8;

endpackage

// File: rtl/xillybus_lite_mailbox_if.sv
// Xillybus Lite user-port bus: host-side register access plus the host interrupt.
interface xillybus_lite_mailbox_if
    import xillybus_lite_mailbox_pkg::*;
#(
    parameter int unsigned ADDR_W = 5
);
    logic [ADDR_W-1:0] user_addr;
    logic              user_wren;
    logic [3:0]        user_wstrb;
    logic [DATA_W-1:0] user_wr_data;
    logic              user_rden;
    logic [DATA_W-1:0] user_rd_data;
    logic              user_irq;

    modport master (
        output user_addr, user_wren, user_wstrb, user_wr_data, user_rden,
        input  user_rd_data, user_irq
    );

    modport slave (
        input  user_addr, user_wren, user_wstrb, user_wr_data, user_rden,
        output user_rd_data, user_irq
    );
endinterface

// File: rtl/mailbox_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with flush; full/empty/count are registered.
module mailbox_sync_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] head_c,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_nxt;
    logic             do_push;
    logic             do_pop;

    // Requests are qualified by the registered flags, so a push never bypasses a same-cycle pop.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head_c  = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        case ({do_push, do_pop})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_nxt;
            full  <= (count_nxt == CNT_W'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/xillybus_lite_mailbox.sv
// Register-mapped H2F/F2H mailbox on the Xillybus Lite user port with a level IRQ to the host.
module xillybus_lite_mailbox
    import xillybus_lite_mailbox_pkg::*;
#(
    parameter int unsigned       DEPTH    = 16,
    parameter int unsigned       ADDR_W   = 5,
    parameter logic [DATA_W-1:0] ID_VALUE = DEFAULT_ID_VALUE
) (
    input  logic                      bus_clk,
    input  logic                      bus_rst_n,
    xillybus_lite_mailbox_if.slave    lite,
    output logic [DATA_W-1:0]         h2f_data,
    output logic                      h2f_valid,
    input  logic                      h2f_ready,
    input  logic [DATA_W-1:0]         f2h_data,
    input  logic                      f2h_valid,
    output logic                      f2h_ready
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned OFF_W = ADDR_W - 2;

    logic [OFF_W-1:0]  word_off;
    logic              wr_ctrl;
    logic              wr_status;
    logic              h2f_push_req;
    logic              rd_f2h;
    logic              h2f_flush;
    logic              f2h_flush;
    logic              h2f_full;
    logic              h2f_empty;
    logic              f2h_full;
    logic              f2h_empty;
    logic [CNT_W-1:0]  h2f_count;
    logic [CNT_W-1:0]  f2h_count;
    logic [DATA_W-1:0] f2h_head;
    logic [DATA_W-1:0] status_c;
    logic [DATA_W-1:0] rd_mux_c;
    logic              irq_en;
    logic              h2f_ovf;
    logic              f2h_unf;
    logic [DATA_W-1:0] rd_data_q;
    logic              irq_q;
    logic              unused_addr_lsb;

    assign word_off        = lite.user_addr[ADDR_W-1:2];
    assign unused_addr_lsb = ^lite.user_addr[1:0];

    // Address decode of the write/read strobes
    assign wr_ctrl      = lite.user_wren & (word_off == OFF_W'(REG_CTRL)) & lite.user_wstrb[0];
    assign wr_status    = lite.user_wren & (word_off == OFF_W'(REG_STATUS)) & lite.user_wstrb[0];
    assign h2f_push_req = lite.user_wren & (word_off == OFF_W'(REG_H2F)) & (lite.user_wstrb == 4'hF);
    assign rd_f2h       = lite.user_rden & (word_off == OFF_W'(REG_F2H));
    assign h2f_flush    = wr_ctrl & lite.user_wr_data[CTRL_H2F_FLUSH];
    assign f2h_flush    = wr_ctrl & lite.user_wr_data[CTRL_F2H_FLUSH];

    mailbox_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W),
        .CNT_W (CNT_W)
    ) u_h2f_fifo (
        .clk     (bus_clk),
        .rst_n   (bus_rst_n),
        .push    (h2f_push_req),
        .pop     (h2f_ready),
        .flush   (h2f_flush),
        .wr_data (lite.user_wr_data),
        .head_c  (h2f_data),
        .full    (h2f_full),
        .empty   (h2f_empty),
        .count   (h2f_count)
    );

    mailbox_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W),
        .CNT_W (CNT_W)
    ) u_f2h_fifo (
        .clk     (bus_clk),
        .rst_n   (bus_rst_n),
        .push    (f2h_valid),
        .pop     (rd_f2h),
        .flush   (f2h_flush),
        .wr_data (f2h_data),
        .head_c  (f2h_head),
        .full    (f2h_full),
        .empty   (f2h_empty),
        .count   (f2h_count)
    );

    assign h2f_valid = ~h2f_empty;
    assign f2h_ready = ~f2h_full;

    // Counts wider than the 8-bit STATUS fields (DEPTH=256) are truncated there.
    always_comb begin
        status_c                               = '0;
        status_c[ST_H2F_FULL]                  = h2f_full;
        status_c[ST_H2F_EMPTY]                 = h2f_empty;
        status_c[ST_F2H_FULL]                  = f2h_full;
        status_c[ST_F2H_EMPTY]                 = f2h_empty;
        status_c[ST_H2F_OVF]                   = h2f_ovf;
        status_c[ST_F2H_UNF]                   = f2h_unf;
        status_c[ST_F2H_CNT_LSB +: ST_CNT_W]   = ST_CNT_W'(f2h_count);
        status_c[ST_H2F_CNT_LSB +: ST_CNT_W]   = ST_CNT_W'(h2f_count);
    end

    always_comb begin
        rd_mux_c = '0;
        case (word_off)
            OFF_W'(REG_ID):     rd_mux_c = ID_VALUE;
            OFF_W'(REG_CTRL):   rd_mux_c[CTRL_IRQ_EN] = irq_en;
            OFF_W'(REG_STATUS): rd_mux_c = status_c;
            OFF_W'(REG_F2H):    rd_mux_c = f2h_empty ? '0 : f2h_head;
            default:            rd_mux_c = '0;
        endcase
    end

    // Control, sticky flags (set wins over a same-cycle W1C), read data and IRQ
    always_ff @(posedge bus_clk) begin
        if (!bus_rst_n) begin
            irq_en    <= 1'b0;
            h2f_ovf   <= 1'b0;
            f2h_unf   <= 1'b0;
            rd_data_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            if (wr_ctrl) irq_en <= lite.user_wr_data[CTRL_IRQ_EN];

            if (h2f_push_req && h2f_full)
                h2f_ovf <= 1'b1;
            else if (wr_status && lite.user_wr_data[ST_H2F_OVF])
                h2f_ovf <= 1'b0;

            if (rd_f2h && f2h_empty)
                f2h_unf <= 1'b1;
            else if (wr_status && lite.user_wr_data[ST_F2H_UNF])
                f2h_unf <= 1'b0;

            if (lite.user_rden) rd_data_q <= rd_mux_c;
            irq_q <= irq_en & ~f2h_empty;
        end
    end

    assign lite.user_rd_data = rd_data_q;
    assign lite.user_irq     = irq_q;

endmodule

// File: tb/tb_xillybus_lite_mailbox.sv
// Directed plus randomized bench for xillybus_lite_mailbox against a queue-based model.
module tb_xillybus_lite_mailbox;

    localparam int unsigned DEPTH  = 16;
    localparam int unsigned ADDR_W = 5;

    logic        clk;
    logic        rst_n;
    logic [31:0] h2f_data;
    logic        h2f_valid;
    logic        h2f_ready;
    logic [31:0] f2h_data;
    logic        f2h_valid;
    logic        f2h_ready;

    xillybus_lite_mailbox_if #(.ADDR_W(ADDR_W)) lite ();

    xillybus_lite_mailbox #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .bus_clk   (clk),
        .bus_rst_n (rst_n),
        .lite      (lite),
        .h2f_data  (h2f_data),
        .h2f_valid (h2f_valid),
        .h2f_ready (h2f_ready),
        .f2h_data  (f2h_data),
        .f2h_valid (f2h_valid),
        .f2h_ready (f2h_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: two queues, three flags, last read word, irq.
    logic [31:0] h2f_q[$];
    logic [31:0] f2h_q[$];
    bit          m_en, m_ovf, m_unf, m_irq;
    logic [31:0] m_rd;

    function automatic logic [31:0] status_word(input int hs, input int fs);
        logic [31:0] s;
        s = 32'((hs % 256) * 65536 + (fs % 256) * 256);
        if (hs == DEPTH) s[0] = 1'b1;
        if (hs == 0)     s[1] = 1'b1;
        if (fs == DEPTH) s[2] = 1'b1;
        if (fs == 0)     s[3] = 1'b1;
        if (m_ovf)       s[4] = 1'b1;
        if (m_unf)       s[5] = 1'b1;
        return s;
    endfunction

    always @(posedge clk) begin
        int          hs, fs, off;
        bit          en0, fl_h, fl_f, wr, rd, h_push;
        logic [31:0] wd;
        if (!rst_n) begin
            h2f_q.delete();
            f2h_q.delete();
            m_en = 0; m_ovf = 0; m_unf = 0; m_irq = 0;
            m_rd = '0;
        end else begin
            hs  = h2f_q.size();
            fs  = f2h_q.size();
            en0 = m_en;
            off = int'(lite.user_addr) / 4;
            wr  = lite.user_wren;
            rd  = lite.user_rden;
            wd  = lite.user_wr_data;
            if (rd) begin
                case (off)
                    0:       m_rd = 32'h4D42_0001;
                    1:       m_rd = {31'b0, m_en};
                    2:       m_rd = status_word(hs, fs);
                    4:       m_rd = (fs > 0) ? f2h_q[0] : 32'h0;
                    default: m_rd = 32'h0;
                endcase
            end
            m_irq  = en0 && (fs != 0);
            fl_h   = 0;
            fl_f   = 0;
            h_push = wr && off == 3 && lite.user_wstrb == 4'hF;
            if (wr && off == 1 && lite.user_wstrb[0]) begin
                m_en = wd[0]; fl_h = wd[1]; fl_f = wd[2];
            end
            if (wr && off == 2 && lite.user_wstrb[0]) begin
                if (wd[4]) m_ovf = 0;
                if (wd[5]) m_unf = 0;
            end
            if (h_push && hs == DEPTH)  m_ovf = 1;
            if (rd && off == 4 && fs == 0) m_unf = 1;
            if (fl_h) h2f_q.delete();
            else begin
                if (h2f_ready && hs > 0) void'(h2f_q.pop_front());
                if (h_push && hs < DEPTH) h2f_q.push_back(wd);
            end
            if (fl_f) f2h_q.delete();
            else begin
                if (rd && off == 4 && fs > 0) void'(f2h_q.pop_front());
                if (f2h_valid && fs < DEPTH) f2h_q.push_back(f2h_data);
            end
        end
    end

    // Per-cycle comparison of every DUT output against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("rd_data", lite.user_rd_data, m_rd);
            chk("irq", {31'b0, lite.user_irq}, {31'b0, m_irq});
            chk("h2f_valid", {31'b0, h2f_valid}, {31'b0, h2f_q.size() != 0});
            if (h2f_q.size() != 0) chk("h2f_data", h2f_data, h2f_q[0]);
            chk("f2h_ready", {31'b0, f2h_ready}, {31'b0, h2f_q.size() >= 0 && f2h_q.size() < DEPTH});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input int off, input logic [31:0] d, input logic [3:0] s);
        lite.user_addr    = 5'(off * 4);
        lite.user_wstrb   = s;
        lite.user_wr_data = d;
        lite.user_wren    = 1'b1;
        tick();
        lite.user_wren    = 1'b0;
    endtask

    task automatic bus_read(input int off);
        lite.user_addr = 5'(off * 4);
        lite.user_rden = 1'b1;
        tick();
        lite.user_rden = 1'b0;
    endtask

    initial begin
        logic [31:0] w [3];
        int          op, off, rb, vb;

        rst_n = 1'b0;
        lite.user_addr = '0; lite.user_wren = 1'b0; lite.user_wstrb = '0;
        lite.user_wr_data = '0; lite.user_rden = 1'b0;
        h2f_ready = 1'b0; f2h_valid = 1'b0; f2h_data = '0;
        tick();
        chk_en = 1'b1;
        tick();
        rst_n = 1'b1;
        chk("rst_rd_data", lite.user_rd_data, 32'h0);
        chk("rst_irq", {31'b0, lite.user_irq}, 32'h0);
        chk("rst_h2f_valid", {31'b0, h2f_valid}, 32'h0);
        chk("rst_f2h_ready", {31'b0, f2h_ready}, 32'h1);

        bus_read(0);
        chk("id", lite.user_rd_data, 32'h4D42_0001);
        bus_read(2);
        chk("status_reset", lite.user_rd_data, 32'h0000_000A);

        w[0] = 32'h1111_0001; w[1] = 32'h2222_0002; w[2] = 32'h3333_0003;
        for (int i = 0; i < 3; i++) bus_write(3, w[i], 4'hF);
        bus_read(2);
        chk("status_h2f3", lite.user_rd_data, 32'h0003_0008);
        h2f_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("h2f_order_valid", {31'b0, h2f_valid}, 32'h1);
            chk("h2f_order_data", h2f_data, w[i]);
            tick();
        end
        @(negedge clk);
        chk("h2f_drained", {31'b0, h2f_valid}, 32'h0);
        tick();
        h2f_ready = 1'b0;

        for (int i = 0; i <= DEPTH; i++) bus_write(3, 32'hA000_0000 + 32'(i), 4'hF);
        bus_read(2);
        chk("status_ovf", lite.user_rd_data, 32'h0010_0019);
        bus_write(2, 32'h0000_0010, 4'hF);
        bus_read(2);
        chk("status_ovf_clr", lite.user_rd_data, 32'h0010_0009);
        bus_write(1, 32'h0000_0002, 4'h1);
        bus_read(2);
        chk("status_h2f_flush", lite.user_rd_data, 32'h0000_000A);

        bus_write(1, 32'h0000_0001, 4'hF);
        f2h_data = 32'hCAFE_0001; f2h_valid = 1'b1;
        tick();
        f2h_valid = 1'b0;
        chk("irq_not_yet", {31'b0, lite.user_irq}, 32'h0);
        tick();
        chk("irq_set", {31'b0, lite.user_irq}, 32'h1);
        bus_read(4);
        chk("f2h_pop_data", lite.user_rd_data, 32'hCAFE_0001);
        chk("irq_still_set", {31'b0, lite.user_irq}, 32'h1);
        tick();
        chk("irq_cleared", {31'b0, lite.user_irq}, 32'h0);

        bus_read(4);
        chk("f2h_empty_read", lite.user_rd_data, 32'h0);
        bus_read(2);
        chk("status_unf", lite.user_rd_data, 32'h0000_002A);
        bus_write(2, 32'h0000_0020, 4'h1);

        f2h_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            f2h_data = 32'hB000_0000 + 32'(i);
            tick();
        end
        bus_write(1, 32'h0000_0004, 4'hF);
        f2h_valid = 1'b0;
        bus_read(2);
        chk("status_f2h_flush", lite.user_rd_data, 32'h0000_000A);
        bus_read(1);
        chk("ctrl_selfclear", lite.user_rd_data, 32'h0);
        bus_write(3, 32'hDEAD_BEEF, 4'h2);
        bus_read(2);
        chk("status_partial_strobe", lite.user_rd_data, 32'h0000_000A);

        // Same-cycle W1C and STATUS read: read sees the pre-write value
        bus_read(4);
        lite.user_addr = 5'(2 * 4); lite.user_wstrb = 4'hF; lite.user_wr_data = 32'h20;
        lite.user_wren = 1'b1; lite.user_rden = 1'b1;
        tick();
        lite.user_wren = 1'b0; lite.user_rden = 1'b0;
        chk("rw_same_cycle", lite.user_rd_data, 32'h0000_002A);
        bus_read(2);
        chk("rw_after", lite.user_rd_data, 32'h0000_000A);

        for (int c = 0; c < 3000; c++) begin
            rb = (c % 1000 < 500) ? 1 : 3;
            vb = (c % 600 < 300) ? 3 : 1;
            lite.user_wren = 1'b0;
            lite.user_rden = 1'b0;
            rst_n     = (c != 1500);
            h2f_ready = ($urandom_range(0, 3) < 32'(rb));
            f2h_valid = ($urandom_range(0, 3) < 32'(vb));
            f2h_data  = $urandom;
            op  = int'($urandom_range(0, 9));
            off = ($urandom_range(0, 1) == 0) ? int'($urandom_range(3, 4)) : int'($urandom_range(0, 7));
            lite.user_addr = 5'(off * 4 + int'($urandom_range(0, 3)));
            if (op < 4) begin
                lite.user_rden = 1'b1;
            end else if (op < 8) begin
                lite.user_wren    = 1'b1;
                lite.user_wstrb   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
                lite.user_wr_data = $urandom;
                if (off == 1 && $urandom_range(0, 7) != 0) lite.user_wr_data[2:1] = 2'b00;
            end
            tick();
        end
        lite.user_wren = 1'b0;
        lite.user_rden = 1'b0;
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
